// File: rtl/left_fifo_burst_reader.sv
// Read-side burst consumer for the left-channel FIFO: pops full (or flushed partial)
// bursts into a 4-entry skid buffer and streams them out with a last marker.
module left_fifo_burst_reader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 64,
    parameter int unsigned OUT_REG    = 0
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_rd_water_level,
    output logic                  fifo_rd_en,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  busy,
    output logic                  flush_done
);

    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PW    = 2;
    localparam int unsigned CW    = 3;
    localparam logic [LW-1:0] BURST_LEN_W = LW'(BURST_LEN);
    localparam bit REG_RD = (OUT_REG != 0);

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e          state_q, state_d;
    logic [LW-1:0]   burst_len_q, burst_len_d;
    logic [LW-1:0]   issued_q, issued_d;
    logic            flush_burst_q, flush_burst_d;
    logic            flush_pending_q, flush_pending_d;
    logic            flush_done_q, flush_done_d;
    logic            inflight_q, inflight_last_q, inflight_tag_q;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] buf_data_q;
    logic [DEPTH-1:0] buf_last_q, buf_tag_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    buf_count_q;

    logic rd_en_c, inflight_c, room_c, word_last_c, word_tag_c;
    logic push_c, push_last_c, push_tag_c, out_fire_c, head_tag_c;

    assign inflight_c  = REG_RD ? inflight_q : 1'b0;
    assign room_c      = (buf_count_q + CW'(inflight_c)) < CW'(DEPTH);
    assign word_last_c = (issued_q == (burst_len_q - LW'(1)));
    assign word_tag_c  = word_last_c && flush_burst_q;

    // With a registered FIFO read port the word lands one cycle after its pop.
    assign push_c      = REG_RD ? inflight_q      : rd_en_c;
    assign push_last_c = REG_RD ? inflight_last_q : word_last_c;
    assign push_tag_c  = REG_RD ? inflight_tag_q  : word_tag_c;

    assign m_valid    = (buf_count_q != '0);
    assign m_data     = buf_data_q[rd_ptr_q];
    assign m_last     = buf_last_q[rd_ptr_q];
    assign head_tag_c = buf_tag_q[rd_ptr_q];
    assign out_fire_c = m_valid && m_ready;
    assign fifo_rd_en = rd_en_c;
    assign busy       = (state_q == ISSUE) || m_valid || inflight_c;
    assign flush_done = flush_done_q;

    // Burst sequencing and flush bookkeeping.
    always_comb begin
        state_d         = state_q;
        burst_len_d     = burst_len_q;
        issued_d        = issued_q;
        flush_burst_d   = flush_burst_q;
        flush_pending_d = flush_pending_q | flush;
        flush_done_d    = out_fire_c && head_tag_c;
        rd_en_c         = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_rd_water_level >= BURST_LEN_W) begin
                    state_d       = ISSUE;
                    burst_len_d   = BURST_LEN_W;
                    issued_d      = '0;
                    flush_burst_d = 1'b0;
                end else if (flush_pending_q && (fifo_rd_water_level != '0)) begin
                    state_d         = ISSUE;
                    burst_len_d     = fifo_rd_water_level;
                    issued_d        = '0;
                    flush_burst_d   = 1'b1;
                    flush_pending_d = 1'b0;
                end else if (flush_pending_q) begin
                    flush_done_d    = 1'b1;
                    flush_pending_d = 1'b0;
                end
            end
            ISSUE: begin
                rd_en_c = !fifo_empty && room_c && (issued_q < burst_len_q);
                if (rd_en_c) begin
                    issued_d = issued_q + LW'(1);
                    if (issued_d == burst_len_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rd_rst) rd_en_c = 1'b0;
    end

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q         <= IDLE;
            burst_len_q     <= '0;
            issued_q        <= '0;
            flush_burst_q   <= 1'b0;
            flush_pending_q <= 1'b0;
            flush_done_q    <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            inflight_tag_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            burst_len_q     <= burst_len_d;
            issued_q        <= issued_d;
            flush_burst_q   <= flush_burst_d;
            flush_pending_q <= flush_pending_d;
            flush_done_q    <= flush_done_d;
            inflight_q      <= rd_en_c;
            inflight_last_q <= word_last_c;
            inflight_tag_q  <= word_tag_c;
        end
    end

    // Skid buffer: circular 4-entry store, push and pop may coincide.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            buf_tag_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            buf_count_q <= '0;
        end else begin
            if (push_c) begin
                buf_data_q[wr_ptr_q] <= fifo_rd_data;
                buf_last_q[wr_ptr_q] <= push_last_c;
                buf_tag_q[wr_ptr_q]  <= push_tag_c;
                wr_ptr_q             <= wr_ptr_q + PW'(1);
            end
            if (out_fire_c) rd_ptr_q <= rd_ptr_q + PW'(1);
            buf_count_q <= buf_count_q + CW'(push_c) - CW'(out_fire_c);
        end
    end

endmodule

// File: tb/tb_left_fifo_burst_reader.sv
// Directed bench: two reader instances (combinational and registered FIFO read port)
// fed by small FIFO models, with beat monitors and hand-computed expectations.
module tb_left_fifo_burst_reader;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- instance 0: BURST_LEN=4, OUT_REG=0 ----------------
    logic [DW-1:0] rdata0, m_data0, pdata0;
    logic          empty0, rd_en0, flush0, m_valid0, m_ready0, m_last0, busy0, fd0, push0;
    logic [AW:0]   level0;
    logic [DW-1:0] mem0 [64];
    logic [6:0]    wp0, rp0;

    assign level0 = 5'(wp0 - rp0);
    assign empty0 = (wp0 == rp0);
    assign rdata0 = mem0[rp0[5:0]];

    always @(posedge clk) begin
        if (rst) begin
            wp0 <= '0;
            rp0 <= '0;
        end else begin
            if (push0) begin
                mem0[wp0[5:0]] <= pdata0;
                wp0 <= wp0 + 7'd1;
            end
            if (rd_en0 && !empty0) rp0 <= rp0 + 7'd1;
        end
    end

    left_fifo_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(4), .OUT_REG(0)) dut0 (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(rdata0), .fifo_empty(empty0),
        .fifo_rd_water_level(level0), .fifo_rd_en(rd_en0), .flush(flush0),
        .m_data(m_data0), .m_valid(m_valid0), .m_ready(m_ready0), .m_last(m_last0),
        .busy(busy0), .flush_done(fd0)
    );

    // ---------------- instance 1: BURST_LEN=8, OUT_REG=1 ----------------
    logic [DW-1:0] rdata1, m_data1, pdata1;
    logic          empty1, rd_en1, flush1, m_valid1, m_ready1, m_last1, busy1, fd1, push1;
    logic [AW:0]   level1;
    logic [DW-1:0] mem1 [64];
    logic [6:0]    wp1, rp1;

    assign level1 = 5'(wp1 - rp1);
    assign empty1 = (wp1 == rp1);

    always @(posedge clk) begin
        if (rst) begin
            wp1    <= '0;
            rp1    <= '0;
            rdata1 <= '0;
        end else begin
            if (push1) begin
                mem1[wp1[5:0]] <= pdata1;
                wp1 <= wp1 + 7'd1;
            end
            if (rd_en1 && !empty1) begin
                rdata1 <= mem1[rp1[5:0]];
                rp1    <= rp1 + 7'd1;
            end
        end
    end

    left_fifo_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(8), .OUT_REG(1)) dut1 (
        .rd_clk(clk), .rd_rst(rst), .fifo_rd_data(rdata1), .fifo_empty(empty1),
        .fifo_rd_water_level(level1), .fifo_rd_en(rd_en1), .flush(flush1),
        .m_data(m_data1), .m_valid(m_valid1), .m_ready(m_ready1), .m_last(m_last1),
        .busy(busy1), .flush_done(fd1)
    );

    // ---------------- monitors ----------------
    logic [DW-1:0] bdata0[$], bdata1[$];
    bit            blast0[$], blast1[$];
    int            bcyc0[$], fdcyc0[$];
    int            rdcnt0 = 0, rdcnt1 = 0;
    int            occ0 = 0, occmax0 = 0, occ1 = 0, occmax1 = 0;
    int            stall_err1 = 0;
    bit            prev_stall1 = 1'b0;
    bit            prev_last1 = 1'b0;
    logic [DW-1:0] prev_data1 = '0;

    always @(negedge clk) begin
        if (rst) begin
            occ0 = 0;
        end else begin
            if (m_valid0 && m_ready0) begin
                bdata0.push_back(m_data0);
                blast0.push_back(m_last0);
                bcyc0.push_back(cyc);
            end
            if (fd0) fdcyc0.push_back(cyc);
            if (rd_en0) rdcnt0++;
            occ0 = occ0 + int'(rd_en0) - int'(m_valid0 && m_ready0);
            if (occ0 > occmax0) occmax0 = occ0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            occ1 = 0;
            prev_stall1 = 1'b0;
        end else begin
            if (m_valid1 && m_ready1) begin
                bdata1.push_back(m_data1);
                blast1.push_back(m_last1);
            end
            if (rd_en1) rdcnt1++;
            occ1 = occ1 + int'(rd_en1) - int'(m_valid1 && m_ready1);
            if (occ1 > occmax1) occmax1 = occ1;
            if (prev_stall1 && (!m_valid1 || m_data1 != prev_data1 || m_last1 != prev_last1))
                stall_err1++;
            prev_stall1 = m_valid1 && !m_ready1;
            prev_data1  = m_data1;
            prev_last1  = m_last1;
        end
    end

    // ---------------- helpers ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_words0(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push0  = 1'b1;
            pdata0 = base + DW'(i);
            tick();
        end
        push0 = 1'b0;
    endtask

    task automatic push_words1(input logic [DW-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push1  = 1'b1;
            pdata1 = base + DW'(i);
            tick();
        end
        push1 = 1'b0;
    endtask

    task automatic wait_beats0(input string tag, input int n, input int base);
        int t = 0;
        while (bdata0.size() < base + n && t < 100) begin
            tick();
            t++;
        end
        repeat (3) tick();
        check({tag, "_count"}, bdata0.size() - base, n);
    endtask

    task automatic check_burst0(input string tag, input int base, input logic [DW-1:0] first,
                                input int n, input int last_a, input int last_b);
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_data%0d", tag, i), bdata0[base+i], first + DW'(i));
            check($sformatf("%s_last%0d", tag, i), blast0[base+i], (i == last_a) || (i == last_b));
        end
    endtask

    // ---------------- stimulus ----------------
    int b, r, f, c0, t;

    initial begin
        rst = 1'b1;
        push0 = 1'b0; pdata0 = '0; flush0 = 1'b0; m_ready0 = 1'b1;
        push1 = 1'b0; pdata1 = '0; flush1 = 1'b0; m_ready1 = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd_en0", rd_en0, 0);
        check("rst_m_valid0", m_valid0, 0);
        check("rst_m_last0", m_last0, 0);
        check("rst_m_data0", m_data0, 0);
        check("rst_busy0", busy0, 0);
        check("rst_flush_done0", fd0, 0);
        check("rst_rd_en1", rd_en1, 0);
        check("rst_m_valid1", m_valid1, 0);
        check("rst_busy1", busy1, 0);

        // Basic 4-word burst, back-to-back beats
        b = bdata0.size(); r = rdcnt0;
        push_words0(16'hA000, 4);
        wait_beats0("basic", 4, b);
        check_burst0("basic", b, 16'hA000, 4, 3, 3);
        check("basic_rd_en_pulses", rdcnt0 - r, 4);
        check("basic_beat_span", bcyc0[b+3] - bcyc0[b], 3);

        // Threshold hold at level 3, start one cycle after level reaches 4
        b = bdata0.size(); r = rdcnt0;
        push_words0(16'hB000, 3);
        repeat (20) tick();
        check("hold_no_rd_en", rdcnt0 - r, 0);
        push0 = 1'b1; pdata0 = 16'hB003;
        tick();
        push0 = 1'b0;
        @(negedge clk);
        check("hold_pre_start", rd_en0, 0);
        tick();
        @(negedge clk);
        check("hold_start", rd_en0, 1);
        wait_beats0("hold", 4, b);
        check_burst0("hold", b, 16'hB000, 4, 3, 3);

        // Partial flush of 3 words
        b = bdata0.size(); f = fdcyc0.size();
        push_words0(16'hC000, 3);
        tick();
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        wait_beats0("flush3", 3, b);
        check_burst0("flush3", b, 16'hC000, 3, 2, 2);
        check("flush3_done_cnt", fdcyc0.size() - f, 1);
        check("flush3_done_lat", fdcyc0[f] - bcyc0[b+2], 1);

        // Flush with an empty FIFO
        f = fdcyc0.size(); r = rdcnt0;
        tick();
        flush0 = 1'b1;
        c0 = cyc;
        tick();
        flush0 = 1'b0;
        repeat (5) tick();
        check("flush0_done_cnt", fdcyc0.size() - f, 1);
        check("flush0_done_lat", fdcyc0[f] - c0, 2);
        check("flush0_no_rd_en", rdcnt0 - r, 0);

        // Six words + flush: full burst then a 2-word flush burst
        b = bdata0.size(); f = fdcyc0.size();
        push_words0(16'hD000, 6);
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        wait_beats0("flush6", 6, b);
        check_burst0("flush6", b, 16'hD000, 6, 3, 5);
        check("flush6_done_cnt", fdcyc0.size() - f, 1);
        check("flush6_done_lat", fdcyc0[f] - bcyc0[b+5], 1);

        // Reset after two beats of a burst
        b = bdata0.size();
        push_words0(16'hE000, 4);
        t = 0;
        while (bdata0.size() < b + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_beats", bdata0.size() - b, 2);
        check_burst0("rstmid", b, 16'hE000, 2, -1, -1);
        check("rstmid_rd_en", rd_en0, 0);
        check("rstmid_m_valid", m_valid0, 0);
        check("rstmid_m_last", m_last0, 0);
        check("rstmid_m_data", m_data0, 0);
        check("rstmid_busy", busy0, 0);
        check("rstmid_flush_done", fd0, 0);
        b = bdata0.size(); r = rdcnt0;
        push_words0(16'hF000, 4);
        wait_beats0("refill", 4, b);
        check_burst0("refill", b, 16'hF000, 4, 3, 3);
        check("refill_rd_en_pulses", rdcnt0 - r, 4);
        check("occupancy0_max", occmax0 <= 4, 1);

        // Registered read port with m_ready toggling every cycle
        b = bdata1.size(); r = rdcnt1;
        push_words1(16'h6000, 8);
        t = 0;
        while (bdata1.size() < b + 8 && t < 200) begin
            m_ready1 = ~m_ready1;
            tick();
            t++;
        end
        m_ready1 = 1'b1;
        repeat (4) tick();
        check("bp_count", bdata1.size() - b, 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_data%0d", i), bdata1[b+i], 16'h6000 + DW'(i));
            check($sformatf("bp_last%0d", i), blast1[b+i], i == 7);
        end
        check("bp_rd_en_pulses", rdcnt1 - r, 8);
        check("bp_stall_stable", stall_err1, 0);
        check("occupancy1_max", occmax1 <= 4, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
